// File: rtl/pc_sequencer.sv
// Program-counter sequencing controller: drives PC enable/source from cache handshakes,
// arbitrates the shared memory port between fetch and data access, latches halt, counts stalls/retires.
module pc_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmem_req,
  input  logic             redirect_valid,
  input  logic [2:0]       redirect_src,
  input  logic             halt,
  output logic             pc_en,
  output logic [2:0]       PCSrc,
  output logic             imemREN,
  output logic             dmem_go,
  output logic             halt_latched,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DATA   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       pend_src;
  logic [2:0]       pend_nxt;
  logic [2:0]       eff_src;
  logic             stall_inc;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] retire_q;

  // Only sources 1-3 are real redirects; everything else falls back to PC+4.
  always_comb begin
    eff_src = 3'd0;
    if (redirect_valid && (redirect_src != 3'd0) && !redirect_src[2])
      eff_src = redirect_src;
  end

  // Outputs are forced to zero for the whole time reset is held.
  always_comb begin
    state_nxt    = state;
    pend_nxt     = pend_src;
    pc_en        = 1'b0;
    PCSrc        = 3'd0;
    imemREN      = 1'b0;
    dmem_go      = 1'b0;
    halt_latched = 1'b0;
    stall_inc    = 1'b0;
    if (!RST) begin
      unique case (state)
        FETCH: begin
          imemREN = 1'b1;
          if (!ihit) begin
            stall_inc = 1'b1;
          end else if (halt) begin
            state_nxt = HALTED;
          end else if (dmem_req) begin
            pend_nxt  = eff_src;
            state_nxt = DATA;
          end else begin
            pc_en = 1'b1;
            PCSrc = eff_src;
          end
        end
        DATA: begin
          dmem_go = 1'b1;
          if (!dhit) begin
            stall_inc = 1'b1;
          end else begin
            pc_en     = 1'b1;
            PCSrc     = pend_src;
            pend_nxt  = 3'd0;
            state_nxt = FETCH;
          end
        end
        HALTED: begin
          halt_latched = 1'b1;
        end
        default: begin
          state_nxt = FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= FETCH;
      pend_src <= 3'd0;
      stall_q  <= '0;
      retire_q <= '0;
    end else begin
      state    <= state_nxt;
      pend_src <= pend_nxt;
      if (stall_inc && (stall_q != {CNT_W{1'b1}}))
        stall_q <= stall_q + CNT_W'(1);
      if (pc_en && (retire_q != {CNT_W{1'b1}}))
        retire_q <= retire_q + CNT_W'(1);
    end
  end

  assign stall_cnt  = RST ? '0 : stall_q;
  assign retire_cnt = RST ? '0 : retire_q;

  // Structural invariants of the output encoding.
  always_ff @(posedge CLK) begin
    assert (!(imemREN && dmem_go));
    assert (pc_en || (PCSrc == 3'd0));
    assert (PCSrc <= 3'd3);
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios plus random traffic checked
// against a cycle-level behavioural model of the sequencing rules.
module tb_pc_sequencer;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          CLK;
  logic          RST;
  logic          ihit;
  logic          dhit;
  logic          dmem_req;
  logic          redirect_valid;
  logic [2:0]    redirect_src;
  logic          halt;
  logic          pc_en;
  logic [2:0]    PCSrc;
  logic          imemREN;
  logic          dmem_go;
  logic          halt_latched;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] retire_cnt;

  pc_sequencer #(.CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
    .redirect_valid(redirect_valid), .redirect_src(redirect_src), .halt(halt),
    .pc_en(pc_en), .PCSrc(PCSrc), .imemREN(imemREN), .dmem_go(dmem_go),
    .halt_latched(halt_latched), .stall_cnt(stall_cnt), .retire_cnt(retire_cnt)
  );

  typedef struct packed {
    logic          pc_en;
    logic [2:0]    pcsrc;
    logic          imem;
    logic          dgo;
    logic          hl;
    logic [CW-1:0] st;
    logic [CW-1:0] rt;
  } exp_t;

  exp_t expq[$];
  int   checks  = 0;
  int   errors  = 0;
  bit   running = 0;

  // Behavioural model: where the processor is, what redirect is owed, and the two counts.
  bit m_halted = 0;
  bit m_in_data = 0;
  int m_pend = 0;
  int m_stall = 0;
  int m_retire = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic applyStimulus(input bit rst, input bit ih, input bit dh, input bit dr,
                               input bit rv, input logic [2:0] rs, input bit hl);
    exp_t e;
    int   eff;
    @(posedge CLK);
    #1;
    RST = rst; ihit = ih; dhit = dh; dmem_req = dr;
    redirect_valid = rv; redirect_src = rs; halt = hl;
    e = '0;
    eff = (rv && rs >= 1 && rs <= 3) ? int'(rs) : 0;
    if (rst) begin
      m_halted = 0; m_in_data = 0; m_pend = 0; m_stall = 0; m_retire = 0;
    end else begin
      e.st = m_stall[CW-1:0];
      e.rt = m_retire[CW-1:0];
      if (m_halted) begin
        e.hl = 1'b1;
      end else if (m_in_data) begin
        e.dgo = 1'b1;
        if (dh) begin
          e.pc_en = 1'b1;
          e.pcsrc = 3'(m_pend);
          m_retire = (m_retire < CMAX) ? m_retire + 1 : CMAX;
          m_in_data = 0;
        end else begin
          m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
        end
      end else begin
        e.imem = 1'b1;
        if (!ih) begin
          m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
        end else if (hl) begin
          m_halted = 1;
        end else if (dr) begin
          m_pend = eff;
          m_in_data = 1;
        end else begin
          e.pc_en = 1'b1;
          e.pcsrc = 3'(eff);
          m_retire = (m_retire < CMAX) ? m_retire + 1 : CMAX;
        end
      end
    end
    expq.push_back(e);
    running = 1;
  endtask

  task automatic checkOutput();
    exp_t e;
    exp_t a;
    a = {pc_en, PCSrc, imemREN, dmem_go, halt_latched, stall_cnt, retire_cnt};
    checks++;
    if (expq.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty: got output %h with no expected entry", a);
    end else begin
      e = expq.pop_front();
      if (a !== e) begin
        errors++;
        $display("[TB] FAIL outputs @%0t: got pc_en=%b PCSrc=%0d imemREN=%b dmem_go=%b halt=%b stall=%0d retire=%0d, expected pc_en=%b PCSrc=%0d imemREN=%b dmem_go=%b halt=%b stall=%0d retire=%0d",
                 $time, a.pc_en, a.pcsrc, a.imem, a.dgo, a.hl, a.st, a.rt,
                 e.pc_en, e.pcsrc, e.imem, e.dgo, e.hl, e.st, e.rt);
      end
    end
  endtask

  always @(negedge CLK) begin
    if (running) checkOutput();
  end

  initial begin
    RST = 1'b1; ihit = 1'b0; dhit = 1'b0; dmem_req = 1'b0;
    redirect_valid = 1'b0; redirect_src = 3'd0; halt = 1'b0;

    // Straight-line fetch after a two-cycle reset.
    repeat (2) applyStimulus(1, 0, 0, 0, 0, 3'd0, 0);
    repeat (6) applyStimulus(0, 1, 0, 0, 0, 3'd0, 0);

    // Load/store with a slow data cache.
    applyStimulus(0, 1, 0, 1, 0, 3'd0, 0);
    repeat (3) applyStimulus(0, 1, 0, 1, 0, 3'd0, 0);
    applyStimulus(0, 0, 1, 0, 0, 3'd0, 0);
    applyStimulus(0, 1, 0, 0, 0, 3'd0, 0);

    // Every redirect source including an out-of-range one.
    applyStimulus(0, 1, 0, 0, 1, 3'd1, 0);
    applyStimulus(0, 1, 0, 0, 1, 3'd2, 0);
    applyStimulus(0, 1, 0, 0, 1, 3'd3, 0);
    applyStimulus(0, 1, 0, 0, 1, 3'd5, 0);
    applyStimulus(0, 1, 0, 0, 0, 3'd2, 0);

    // Redirect carried across a data access.
    applyStimulus(0, 1, 0, 1, 1, 3'd3, 0);
    applyStimulus(0, 1, 1, 1, 1, 3'd1, 1);

    // Halt beats a simultaneous memory request and only reset escapes it.
    applyStimulus(0, 1, 0, 1, 1, 3'd2, 1);
    for (int i = 0; i < 10; i++)
      applyStimulus(0, i[0], ~i[0], 1, 1, 3'd1, 1);
    applyStimulus(1, 1, 1, 0, 0, 3'd0, 0);
    applyStimulus(0, 1, 0, 0, 0, 3'd0, 0);

    // Stall counter saturation.
    repeat (20) applyStimulus(0, 0, 0, 0, 0, 3'd0, 0);

    // Reset in the middle of a data access drops the owed redirect.
    applyStimulus(0, 1, 0, 1, 1, 3'd2, 0);
    applyStimulus(0, 0, 0, 0, 0, 3'd0, 0);
    applyStimulus(1, 0, 1, 0, 0, 3'd0, 0);
    applyStimulus(0, 1, 1, 0, 0, 3'd0, 0);
    applyStimulus(0, 0, 1, 0, 0, 3'd0, 0);

    // Random traffic with occasional resets and halts.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 39) == 0),
                    ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 1) == 1),
                    3'($urandom_range(0, 7)),
                    ($urandom_range(0, 59) == 0));
    end

    @(posedge CLK);
    #1;
    if (expq.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", expq.size());
    end
    running = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
